// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: R15 handling, IR field positions for load
// detection, and the NOP encoding used for bubbles.
package pipeline_pkg;

  localparam int unsigned DW_DEF      = 32;
  localparam int unsigned AW_DEF      = 4;
  localparam logic [3:0]  REG_PC      = 4'd15;
  localparam int unsigned PC_OFFSET   = 8;

  localparam int unsigned IR_CLASS_HI = 27;
  localparam int unsigned IR_CLASS_LO = 26;
  localparam int unsigned IR_L_BIT    = 20;
  localparam int unsigned IR_RD_HI    = 15;
  localparam int unsigned IR_RD_LO    = 12;

  localparam logic [1:0]  CLASS_LDST  = 2'b01;
  localparam logic [31:0] NOP_IR      = 32'h0;

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-source operand selector: R15 reads as PC+offset, otherwise the
// youngest matching in-flight result (EX, then MEM, then WB) beats the
// register file.
module operand_fwd_mux #(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 4,
  parameter int unsigned PC_OFFSET = 8
) (
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] rf_data,
  input  logic [DW-1:0] pc,
  input  logic          fx_we,
  input  logic [AW-1:0] fx_addr,
  input  logic [DW-1:0] fx_data,
  input  logic          fm_we,
  input  logic [AW-1:0] fm_addr,
  input  logic [DW-1:0] fm_data,
  input  logic          fw_we,
  input  logic [AW-1:0] fw_addr,
  input  logic [DW-1:0] fw_data,
  output logic [DW-1:0] operand
);
  import pipeline_pkg::*;

  // Priority select; R15 is never forwarded.
  always_comb begin
    operand = rf_data;
    if (addr == AW'(REG_PC)) begin
      operand = pc + DW'(PC_OFFSET);
    end else if (fx_we && (fx_addr == addr)) begin
      operand = fx_data;
    end else if (fm_we && (fm_addr == addr)) begin
      operand = fm_data;
    end else if (fw_we && (fw_addr == addr)) begin
      operand = fw_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the shifter/ALU. Captures IR, PC and
// forwarded Rn/Rm operands. Load-use bubble insertion is built only when
// the macro ID_EX_LOAD_USE_EN is defined; otherwise hazard_stall is 0.
module id_ex_operand_stage #(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 4,
  parameter int unsigned PC_OFFSET = pipeline_pkg::PC_OFFSET
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_ir,
  input  logic [DW-1:0] id_pc,
  input  logic [AW-1:0] id_rn_addr,
  input  logic [AW-1:0] id_rm_addr,
  input  logic          id_rn_used,
  input  logic          id_rm_used,
  input  logic [DW-1:0] id_rn_data,
  input  logic [DW-1:0] id_rm_data,
  input  logic          fx_we,
  input  logic [AW-1:0] fx_addr,
  input  logic [DW-1:0] fx_data,
  input  logic          fm_we,
  input  logic [AW-1:0] fm_addr,
  input  logic [DW-1:0] fm_data,
  input  logic          fw_we,
  input  logic [AW-1:0] fw_addr,
  input  logic [DW-1:0] fw_data,
  output logic          hazard_stall,
  output logic          ex_valid,
  output logic [DW-1:0] ex_ir,
  output logic [DW-1:0] ex_pc,
  output logic [DW-1:0] ex_rn,
  output logic [DW-1:0] ex_rm
);
  import pipeline_pkg::*;

  logic          ex_valid_q, ex_valid_d;
  logic [DW-1:0] ex_ir_q,    ex_ir_d;
  logic [DW-1:0] ex_pc_q,    ex_pc_d;
  logic [DW-1:0] ex_rn_q,    ex_rn_d;
  logic [DW-1:0] ex_rm_q,    ex_rm_d;
  logic [DW-1:0] rn_fwd,     rm_fwd;

  operand_fwd_mux #(.DW(DW), .AW(AW), .PC_OFFSET(PC_OFFSET)) u_rn_mux (
    .addr    (id_rn_addr),
    .rf_data (id_rn_data),
    .pc      (id_pc),
    .fx_we   (fx_we),
    .fx_addr (fx_addr),
    .fx_data (fx_data),
    .fm_we   (fm_we),
    .fm_addr (fm_addr),
    .fm_data (fm_data),
    .fw_we   (fw_we),
    .fw_addr (fw_addr),
    .fw_data (fw_data),
    .operand (rn_fwd)
  );

  operand_fwd_mux #(.DW(DW), .AW(AW), .PC_OFFSET(PC_OFFSET)) u_rm_mux (
    .addr    (id_rm_addr),
    .rf_data (id_rm_data),
    .pc      (id_pc),
    .fx_we   (fx_we),
    .fx_addr (fx_addr),
    .fx_data (fx_data),
    .fm_we   (fm_we),
    .fm_addr (fm_addr),
    .fm_data (fm_data),
    .fw_we   (fw_we),
    .fw_addr (fw_addr),
    .fw_data (fw_data),
    .operand (rm_fwd)
  );

`ifdef ID_EX_LOAD_USE_EN
  logic          ex_is_load;
  logic [AW-1:0] ex_rd;
  logic          load_use;

  // A load in EX whose destination is read by the valid decoded instruction.
  always_comb begin
    ex_is_load = ex_valid_q
               && (ex_ir_q[IR_CLASS_HI:IR_CLASS_LO] == CLASS_LDST)
               && ex_ir_q[IR_L_BIT];
    ex_rd      = AW'(ex_ir_q[IR_RD_HI:IR_RD_LO]);
    load_use   = 1'b0;
    if (ex_is_load && id_valid && (ex_rd != AW'(REG_PC))) begin
      load_use = (id_rn_used && (id_rn_addr == ex_rd))
              || (id_rm_used && (id_rm_addr == ex_rd));
    end
  end

  assign hazard_stall = load_use && !stall && !flush;
`else
  logic unused_src_used;
  assign unused_src_used = id_rn_used ^ id_rm_used;
  assign hazard_stall    = 1'b0;
`endif

  // Next-state selection: flush, then stall hold, then bubble, then load.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_ir_d    = ex_ir_q;
    ex_pc_d    = ex_pc_q;
    ex_rn_d    = ex_rn_q;
    ex_rm_d    = ex_rm_q;
    if (flush || (!stall && hazard_stall)) begin
      ex_valid_d = 1'b0;
      ex_ir_d    = DW'(NOP_IR);
      ex_pc_d    = '0;
      ex_rn_d    = '0;
      ex_rm_d    = '0;
    end else if (!stall) begin
      ex_valid_d = id_valid;
      ex_ir_d    = id_ir;
      ex_pc_d    = id_pc;
      ex_rn_d    = rn_fwd;
      ex_rm_d    = rm_fwd;
    end
  end

  // Stage register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_valid_q <= 1'b0;
      ex_ir_q    <= '0;
      ex_pc_q    <= '0;
      ex_rn_q    <= '0;
      ex_rm_q    <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_ir_q    <= ex_ir_d;
      ex_pc_q    <= ex_pc_d;
      ex_rn_q    <= ex_rn_d;
      ex_rm_q    <= ex_rm_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_ir    = ex_ir_q;
  assign ex_pc    = ex_pc_q;
  assign ex_rn    = ex_rn_q;
  assign ex_rm    = ex_rm_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage with an expected-output queue.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset_n, stall, flush, id_valid;
  logic [31:0] id_ir, id_pc, id_rn_data, id_rm_data;
  logic [3:0]  id_rn_addr, id_rm_addr;
  logic        id_rn_used, id_rm_used;
  logic        fx_we, fm_we, fw_we;
  logic [3:0]  fx_addr, fm_addr, fw_addr;
  logic [31:0] fx_data, fm_data, fw_data;
  logic        hazard_stall, ex_valid;
  logic [31:0] ex_ir, ex_pc, ex_rn, ex_rm;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  typedef struct {
    string       tag;
    logic        v;
    logic [31:0] ir, pc, rn, rm;
    logic        chk_data;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [31:0] LDR_R2 = 32'hE591_2000;
  localparam logic [31:0] ADD_R3 = 32'hE081_3002;

  id_ex_operand_stage dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_ir(id_ir), .id_pc(id_pc),
    .id_rn_addr(id_rn_addr), .id_rm_addr(id_rm_addr),
    .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
    .id_rn_data(id_rn_data), .id_rm_data(id_rm_data),
    .fx_we(fx_we), .fx_addr(fx_addr), .fx_data(fx_data),
    .fm_we(fm_we), .fm_addr(fm_addr), .fm_data(fm_data),
    .fw_we(fw_we), .fw_addr(fw_addr), .fw_data(fw_data),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid),
    .ex_ir(ex_ir), .ex_pc(ex_pc), .ex_rn(ex_rn), .ex_rm(ex_rm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic push(input string tag, input logic v, input logic [31:0] ir,
                      input logic [31:0] pc, input logic [31:0] rn,
                      input logic [31:0] rm, input logic chk_data);
    exp_t e;
    e.tag = tag; e.v = v; e.ir = ir; e.pc = pc; e.rn = rn; e.rm = rm;
    e.chk_data = chk_data;
    exp_q.push_back(e);
  endtask

  // Advance one edge, then compare the oldest queued expectation.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, ".valid"}, {31'b0, ex_valid}, {31'b0, e.v});
      chk({e.tag, ".ir"}, ex_ir, e.ir);
      if (e.chk_data) begin
        chk({e.tag, ".pc"}, ex_pc, e.pc);
        chk({e.tag, ".rn"}, ex_rn, e.rn);
        chk({e.tag, ".rm"}, ex_rm, e.rm);
      end
    end
  endtask

  // Sample the combinational hazard output between edges.
  task automatic chk_hz(input string tag, input logic want);
    #1;
    chk(tag, {31'b0, hazard_stall}, {31'b0, want});
  endtask

  task automatic idle();
    reset_n = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_ir = '0; id_pc = '0; id_rn_data = '0; id_rm_data = '0;
    id_rn_addr = '0; id_rm_addr = '0; id_rn_used = 1'b0; id_rm_used = 1'b0;
    fx_we = 1'b0; fm_we = 1'b0; fw_we = 1'b0;
    fx_addr = '0; fm_addr = '0; fw_addr = '0;
    fx_data = '0; fm_data = '0; fw_data = '0;
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] pc,
                       input logic [3:0] rn_a, input logic [31:0] rn_d, input logic rn_u,
                       input logic [3:0] rm_a, input logic [31:0] rm_d, input logic rm_u);
    id_valid = 1'b1; id_ir = ir; id_pc = pc;
    id_rn_addr = rn_a; id_rn_data = rn_d; id_rn_used = rn_u;
    id_rm_addr = rm_a; id_rm_data = rm_d; id_rm_used = rm_u;
  endtask

  logic exp_hz;

  initial begin
`ifdef ID_EX_LOAD_USE_EN
    exp_hz = 1'b1;
`else
    exp_hz = 1'b0;
`endif
    idle();
    #2;

    // Reset dominates a valid decode.
    reset_n = 1'b0;
    drive(32'hE081_0002, 32'h40, 4'd1, 32'hAAAA, 1'b1, 4'd2, 32'hBBBB, 1'b1);
    push("rst1", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1); tick();
    push("rst2", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1); tick();
    reset_n = 1'b1;
    push("first_load", 1'b1, 32'hE081_0002, 32'h40, 32'hAAAA, 32'hBBBB, 1'b1); tick();

    // Forward priority EX > MEM > WB > regfile.
    drive(32'hE080_1003, 32'h50, 4'd3, 32'h99, 1'b1, 4'd4, 32'h44, 1'b1);
    fx_we = 1'b1; fx_addr = 4'd3; fx_data = 32'd11;
    fm_we = 1'b1; fm_addr = 4'd3; fm_data = 32'd22;
    fw_we = 1'b1; fw_addr = 4'd3; fw_data = 32'd33;
    push("fwd_ex", 1'b1, 32'hE080_1003, 32'h50, 32'd11, 32'h44, 1'b1); tick();
    fx_we = 1'b0;
    push("fwd_mem", 1'b1, 32'hE080_1003, 32'h50, 32'd22, 32'h44, 1'b1); tick();
    fm_we = 1'b0;
    push("fwd_wb", 1'b1, 32'hE080_1003, 32'h50, 32'd33, 32'h44, 1'b1); tick();
    fw_we = 1'b0;
    push("fwd_none", 1'b1, 32'hE080_1003, 32'h50, 32'h99, 32'h44, 1'b1); tick();

    // R15 reads PC+8 even when EX writes R15; wraps modulo 2^32.
    drive(32'hE080_000F, 32'h100, 4'd1, 32'h5, 1'b1, 4'd15, 32'h777, 1'b1);
    fx_we = 1'b1; fx_addr = 4'd15; fx_data = 32'hDEAD;
    push("r15_pc", 1'b1, 32'hE080_000F, 32'h100, 32'h5, 32'h108, 1'b1); tick();
    fx_we = 1'b0;
    drive(32'hE08F_0001, 32'hFFFF_FFFC, 4'd15, 32'h5, 1'b1, 4'd1, 32'h6, 1'b1);
    push("r15_wrap", 1'b1, 32'hE08F_0001, 32'hFFFF_FFFC, 32'h4, 32'h6, 1'b1); tick();

    // Load-use: LDR R2 in EX, dependent ADD in decode.
    drive(LDR_R2, 32'h200, 4'd1, 32'h1000, 1'b1, 4'd0, 32'h0, 1'b0);
    push("ldr", 1'b1, LDR_R2, 32'h200, 32'h1000, 32'h0, 1'b1); tick();
    drive(ADD_R3, 32'h204, 4'd1, 32'h1000, 1'b1, 4'd2, 32'h0, 1'b1);
    chk_hz("lu_hazard", exp_hz);
    if (exp_hz)
      push("lu_bubble", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    else
      push("lu_nobubble", 1'b1, ADD_R3, 32'h204, 32'h1000, 32'h0, 1'b1);
    tick();
    fm_we = 1'b1; fm_addr = 4'd2; fm_data = 32'h55;
    chk_hz("lu_after_hz", 1'b0);
    push("lu_fwd_mem", 1'b1, ADD_R3, 32'h204, 32'h1000, 32'h55, 1'b1); tick();
    fm_we = 1'b0;

    // Unused Rm never stalls.
    drive(LDR_R2, 32'h208, 4'd1, 32'h1000, 1'b1, 4'd0, 32'h0, 1'b0);
    push("ldr2", 1'b1, LDR_R2, 32'h208, 32'h1000, 32'h0, 1'b1); tick();
    drive(ADD_R3, 32'h20C, 4'd1, 32'h1000, 1'b1, 4'd2, 32'h66, 1'b0);
    chk_hz("unused_rm_hz", 1'b0);
    push("unused_rm", 1'b1, ADD_R3, 32'h20C, 32'h1000, 32'h66, 1'b1); tick();

    // Invalid decode loads a bubble and never stalls.
    drive(LDR_R2, 32'h210, 4'd1, 32'h1000, 1'b1, 4'd0, 32'h0, 1'b0);
    push("ldr3", 1'b1, LDR_R2, 32'h210, 32'h1000, 32'h0, 1'b1); tick();
    drive(ADD_R3, 32'h214, 4'd1, 32'h1000, 1'b1, 4'd2, 32'h66, 1'b1);
    id_valid = 1'b0;
    chk_hz("invalid_id_hz", 1'b0);
    push("invalid_id", 1'b0, ADD_R3, 32'h214, 32'h1000, 32'h66, 1'b1); tick();

    // Stall holds contents and masks hazard_stall.
    drive(LDR_R2, 32'h300, 4'd1, 32'h2000, 1'b1, 4'd0, 32'h0, 1'b0);
    push("pre_stall", 1'b1, LDR_R2, 32'h300, 32'h2000, 32'h0, 1'b1); tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(ADD_R3, 32'h304 + 32'(4 * i), 4'd1, 32'h3000 + 32'(i), 1'b1,
            4'd2, 32'h4000 + 32'(i), 1'b1);
      chk_hz($sformatf("stall%0d_hz", i), 1'b0);
      push($sformatf("stall%0d", i), 1'b1, LDR_R2, 32'h300, 32'h2000, 32'h0, 1'b1);
      tick();
    end
    flush = 1'b1;
    chk_hz("flush_stall_hz", 1'b0);
    push("flush_stall", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1); tick();
    stall = 1'b0; flush = 1'b0;
    drive(ADD_R3, 32'h400, 4'd1, 32'h7, 1'b1, 4'd2, 32'h8, 1'b1);
    chk_hz("post_flush_hz", 1'b0);
    push("post_flush", 1'b1, ADD_R3, 32'h400, 32'h7, 32'h8, 1'b1); tick();

    if (exp_q.size() != 0) chk("queue_leftover", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
